// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding, FSM states, PC step.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pc_pkg;

  // Next-PC source select as driven on the pcsrc port
  typedef enum logic [1:0] {
    SEQ    = 2'b00,
    BRANCH = 2'b01,
    JALR   = 2'b10,
    TRAP   = 2'b11
  } pcsrc_e;

  // Sequencer states: BOOT holds the reset vector for one edge, FAULT parks on a misaligned target
  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } pc_state_e;

  // Byte distance between consecutive instructions
  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, push overwrites oldest when full, pop on empty is dropped.
// Latency: push/pop take effect on the clock edge; top/valid are registered-state views.
// Backpressure: none; the caller qualifies push/pop with its own advance condition.
module pc_ras #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDRESS_WIDTH-1:0] push_dat,
  output logic [ADDRESS_WIDTH-1:0] top,
  output logic                     valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]            ptr_q;
  logic [PW-1:0]            ptr_inc;
  logic [PW-1:0]            ptr_dec;
  logic [CW-1:0]            cnt_q;
  logic                     empty;

  // ptr_q always points at the most recent entry; depth is a power of two so the index wraps naturally
  assign ptr_inc = ptr_q + 1'b1;
  assign ptr_dec = ptr_q - 1'b1;
  assign empty   = (cnt_q == '0);

  // Stack update: replace on call+ret, circular push, guarded pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && pop && !empty) begin
      mem[ptr_q] <= push_dat;
    end else if (push) begin
      ptr_q        <= ptr_inc;
      mem[ptr_inc] <= push_dat;
      if (cnt_q != FULL) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign valid = !empty;
  assign top   = empty ? '0 : mem[ptr_q];

endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/FAULT sequencing and optional return-address stack (PC_UNIT_RAS_EN).
// Latency: pc loads the selected target one edge after it is presented; next_pc/pcplus4 are combinational.
// Backpressure: stall=1 freezes pc, FSM and RAS for the cycle; next_pc keeps showing the target.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                       RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [1:0]               pcsrc,
  input  logic [DATA_WIDTH-1:0]    immext,
  input  logic [DATA_WIDTH-1:0]    rs1,
  input  logic [ADDRESS_WIDTH-1:0] trap_vector,
  input  logic                     call,
  input  logic                     ret,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pcplus4,
  output logic [ADDRESS_WIDTH-1:0] next_pc,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] ras_top,
  output logic                     ras_valid
);

  pc_state_e                state_q;
  pc_state_e                state_d;
  pcsrc_e                   src;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] imm_a;
  logic [ADDRESS_WIDTH-1:0] rs1_a;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     tgt_ok;
  logic                     pc_load;
  logic                     run_adv;

  assign src     = pcsrc_e'(pcsrc);
  // Operands are resized to the PC width; the immediate keeps its sign, sums wrap mod 2^ADDRESS_WIDTH
  assign imm_a   = ADDRESS_WIDTH'($signed(immext));
  assign rs1_a   = ADDRESS_WIDTH'(rs1);
  assign pc      = pc_q;
  assign pcplus4 = pc_q + ADDRESS_WIDTH'(PC_INC);

  // Candidate target for the current pcsrc
  always_comb begin
    target = pcplus4;
    case (src)
      SEQ:     target = pcplus4;
      BRANCH:  target = pc_q + imm_a;
      JALR: begin
        target    = rs1_a + imm_a;
        target[0] = 1'b0;
      end
      TRAP:    target = trap_vector;
      default: target = pcplus4;
    endcase
  end

  // Trap handlers are entered whatever their alignment; everything else must be word aligned
  assign tgt_ok = (target[1:0] == 2'b00) || (src == TRAP);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: BOOT lasts one edge, misaligned target parks in FAULT until an unstalled TRAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!stall && !tgt_ok) state_d = FAULT;
      FAULT:   if (!stall && (src == TRAP)) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: next_pc shows what the next unstalled edge would load, pc_load when this edge loads it
  always_comb begin
    next_pc = pc_q;
    pc_load = 1'b0;
    case (state_q)
      BOOT: next_pc = RESET_VECTOR;
      RUN: begin
        if (stall) begin
          next_pc = target;
        end else if (tgt_ok) begin
          next_pc = target;
          pc_load = 1'b1;
        end
      end
      FAULT: begin
        if (src == TRAP) begin
          next_pc = trap_vector;
          pc_load = !stall;
        end
      end
      default: next_pc = RESET_VECTOR;
    endcase
  end

  assign fault   = (state_q == FAULT);
  // Only a real advance out of RUN may touch the return-address stack
  assign run_adv = (state_q == RUN) && pc_load;

  // PC register: pinned to the reset vector while booting, otherwise loads on an advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else if (state_q == BOOT) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_load) begin
      pc_q <= next_pc;
    end
  end

`ifdef PC_UNIT_RAS_EN
  pc_ras #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RAS_DEPTH     (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (run_adv & call),
    .pop      (run_adv & ret),
    .push_dat (pcplus4),
    .top      (ras_top),
    .valid    (ras_valid)
  );
`else
  logic unused_ras;
  assign unused_ras = ^{call, ret, run_adv, (RAS_DEPTH > 1)};
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: driver queues expected outputs, negedge monitor compares.
// Latency: one expectation per cycle, checked at the falling edge of the cycle it was issued in.
// Backpressure: stall and reset are exercised as part of the directed vectors.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    string         nm;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          f;
    logic [AW-1:0] top;
    logic          v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic [1:0]    pcsrc = 2'b00;
  logic [DW-1:0] immext = '0;
  logic [DW-1:0] rs1 = '0;
  logic [AW-1:0] trap_vector = '0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] pc;
  logic [AW-1:0] pcplus4;
  logic [AW-1:0] next_pc;
  logic          fault;
  logic [AW-1:0] ras_top;
  logic          ras_valid;

  exp_t exp_q[$];
  logic mon_vld = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pc_unit #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .RESET_VECTOR  (32'h0),
    .RAS_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .immext      (immext),
    .rs1         (rs1),
    .trap_vector (trap_vector),
    .call        (call),
    .ret         (ret),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .next_pc     (next_pc),
    .fault       (fault),
    .ras_top     (ras_top),
    .ras_valid   (ras_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expectation consumed per falling edge while the driver is active
  always @(negedge clk) begin
    if (mon_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.nm, "pc",        pc,              e.pc);
        chk(e.nm, "pcplus4",   pcplus4,         e.pc + 32'd4);
        chk(e.nm, "next_pc",   next_pc,         e.npc);
        chk(e.nm, "fault",     AW'(fault),      AW'(e.f));
        chk(e.nm, "ras_top",   ras_top,         e.top);
        chk(e.nm, "ras_valid", AW'(ras_valid),  AW'(e.v));
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue what the outputs must show this cycle
  task automatic step(input string nm, input logic r, input logic st, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] tv,
                      input logic c, input logic rt,
                      input logic [31:0] e_pc, input logic [31:0] e_npc, input logic e_f,
                      input logic [31:0] e_top, input logic e_v);
    exp_t e;
    @(posedge clk);
    #1;
    stall       = st;
    pcsrc       = src;
    immext      = imm;
    rs1         = r1;
    trap_vector = tv;
    call        = c;
    ret         = rt;
    #2;
    rst = r;
    e.nm  = nm;
    e.pc  = e_pc;
    e.npc = e_npc;
    e.f   = e_f;
`ifdef PC_UNIT_RAS_EN
    e.top = e_top;
    e.v   = e_v;
`else
    e.top = '0;
    e.v   = 1'b0;
`endif
    exp_q.push_back(e);
    mon_vld = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    //    name             rst st src     imm           rs1           tv            c  r  pc            next_pc       f  ras_top       v
    step("rst_hold",       0, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("boot",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("seq0",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h4,        0, 32'h0,        0);
    step("seq4",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h4,        32'h8,        0, 32'h0,        0);
    step("jalr_100",       1, 0, JALR,   32'h0,        32'h100,      32'h0,        0, 0, 32'h8,        32'h100,      0, 32'h0,        0);
    step("branch_back",    1, 0, BRANCH, 32'hFFFFFFF0, 32'h0,        32'h0,        0, 0, 32'h100,      32'hF0,       0, 32'h0,        0);
    step("jalr_ret",       1, 0, JALR,   32'h0,        32'h100,      32'h0,        0, 0, 32'hF0,       32'h100,      0, 32'h0,        0);
    step("branch_stall",   1, 1, BRANCH, 32'hFFFFFFF0, 32'h0,        32'h0,        0, 0, 32'h100,      32'hF0,       0, 32'h0,        0);
    step("branch_stall2",  1, 1, BRANCH, 32'hFFFFFFF0, 32'h0,        32'h0,        0, 0, 32'h100,      32'hF0,       0, 32'h0,        0);
    step("jalr_clr0",      1, 0, JALR,   32'h0,        32'h201,      32'h0,        0, 0, 32'h100,      32'h200,      0, 32'h0,        0);
    step("branch_misal",   1, 0, BRANCH, 32'h2,        32'h0,        32'h0,        0, 0, 32'h200,      32'h200,      0, 32'h0,        0);
    step("fault_seq",      1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h200,      32'h200,      1, 32'h0,        0);
    step("fault_jalr",     1, 0, JALR,   32'h0,        32'h300,      32'h0,        0, 0, 32'h200,      32'h200,      1, 32'h0,        0);
    step("fault_trap",     1, 0, TRAP,   32'h0,        32'h0,        32'h80,       0, 0, 32'h200,      32'h80,       1, 32'h0,        0);
    step("trap_misal",     1, 0, TRAP,   32'h0,        32'h0,        32'h83,       0, 0, 32'h80,       32'h83,       0, 32'h0,        0);
    step("trap_top",       1, 0, TRAP,   32'h0,        32'h0,        32'hFFFFFFFC, 0, 0, 32'h83,       32'hFFFFFFFC, 0, 32'h0,        0);
    step("seq_wrap",       1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        0);
    step("seq_after_wrap", 1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h4,        0, 32'h0,        0);
    step("stall_at4",      1, 1, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h4,        32'h8,        0, 32'h0,        0);
    step("rst_mid_stall",  0, 1, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("boot2",          1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("to_10",          1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        0, 0, 32'h0,        32'h10,       0, 32'h0,        0);
    step("call_stalled",   1, 1, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h10,       32'h20,       0, 32'h0,        0);
    step("call_10",        1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h10,       32'h20,       0, 32'h0,        0);
    step("call_20",        1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h20,       32'h30,       0, 32'h14,       1);
    step("call_30",        1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h30,       32'h40,       0, 32'h24,       1);
    step("call_40",        1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h40,       32'h50,       0, 32'h34,       1);
    step("call_50",        1, 0, BRANCH, 32'h10,       32'h0,        32'h0,        1, 0, 32'h50,       32'h60,       0, 32'h44,       1);
    step("call_misal",     1, 0, BRANCH, 32'h1,        32'h0,        32'h0,        1, 0, 32'h60,       32'h60,       0, 32'h54,       1);
    step("call_in_fault",  1, 0, TRAP,   32'h0,        32'h0,        32'h60,       1, 0, 32'h60,       32'h60,       1, 32'h54,       1);
    step("ret1",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h60,       32'h64,       0, 32'h54,       1);
    step("ret2",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h64,       32'h68,       0, 32'h44,       1);
    step("ret_stalled",    1, 1, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h68,       32'h6C,       0, 32'h34,       1);
    step("ret3",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h68,       32'h6C,       0, 32'h34,       1);
    step("ret4",           1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h6C,       32'h70,       0, 32'h24,       1);
    step("ret_empty",      1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h70,       32'h74,       0, 32'h0,        0);
    step("callret_empty",  1, 0, SEQ,    32'h0,        32'h0,        32'h0,        1, 1, 32'h74,       32'h78,       0, 32'h0,        0);
    step("call_78",        1, 0, SEQ,    32'h0,        32'h0,        32'h0,        1, 0, 32'h78,       32'h7C,       0, 32'h78,       1);
    step("callret_7c",     1, 0, SEQ,    32'h0,        32'h0,        32'h0,        1, 1, 32'h7C,       32'h80,       0, 32'h7C,       1);
    step("ret_80",         1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h80,       32'h84,       0, 32'h80,       1);
    step("seq_84",         1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h84,       32'h88,       0, 32'h78,       1);
    step("rst_ras",        0, 1, SEQ,    32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("boot3_call",     1, 0, SEQ,    32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h0,        0);
    step("ras_cleared",    1, 0, SEQ,    32'h0,        32'h0,        32'h0,        0, 1, 32'h0,        32'h4,        0, 32'h0,        0);
    @(negedge clk);
    #1;
    mon_vld = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
